mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- Load/store initiator that drives the word-addressed data RAM port (we, a, wd, rd) on behalf of the multicycle core.
- Accepts one RISC-V load or store per request (LB/LH/LW/LBU/LHU/SB/SH/SW selected by funct3).
- Performs read-modify-write for sub-word stores, because the RAM has no byte enables.
- Sign- or zero-extends load data and flags misaligned or illegal accesses.

Parameters:
- ADDR_WIDTH, 32, width of req_addr and mem_a.
- DATA_WIDTH, 32, data width; only 32 is supported.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request (high only in IDLE).
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3 size/sign code.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned or illegal funct3, qualified by resp_valid.
- mem_we  out  1  RAM write enable.
- mem_a  out  ADDR_WIDTH  RAM byte address, bits [1:0] always 00.
- mem_wd  out  32  RAM write data.
- mem_rd  in  32  RAM combinational read data.

Behaviour:
- Reset: state IDLE; all registers 0. Outputs: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_we=0, mem_a=0, mem_wd=0.
- Handshake: a request is accepted on the edge where req_valid && req_ready. The unit latches we, funct3, addr and wdata. req_ready is 0 from the next cycle until the return to IDLE. No pipelining: one request outstanding at a time.
- mem_a is {addr_q[31:2],2'b00}, registered. mem_we=1 only in state WRITE and is gated by !reset.
- States:
  - IDLE: on accept, go to ERR if the request is illegal or misaligned. Otherwise go to READ for a load or a sub-word store, or WRITE for SW.
  - READ: mem_a driven; mem_rd captured at the end of the cycle. Load → DONE with the extracted result. Sub-word store → WRITE, with the merged word latched into mem_wd.
  - WRITE: mem_we=1 for exactly one cycle, then DONE.
  - DONE / ERR: resp_valid=1 for one cycle, resp_err=0 / 1 respectively, then IDLE.
- Latency from the accept edge to resp_valid high:
  - load: 2 cycles.
  - SW: 2 cycles.
  - SB/SH: 3 cycles.
  - error: 1 cycle.
- Legal funct3 values:
  - loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - stores: 000 SB, 001 SH, 010 SW.
  - Any other value sets resp_err with no RAM access.
- Load extract: byte lane is addr[1:0] (lane 0 = bits [7:0]); halfword is selected by addr[1]. LB/LH sign-extend, LBU/LHU zero-extend.
- Store merge: replace only the addressed byte (SB) or half (SH) of the mem_rd word with req_wdata[7:0] or [15:0]. All other bits are written back unchanged.
- Misaligned: halfword access with addr[0]=1, or word access with addr[1:0]≠00.
- req_valid while busy is ignored, not queued.
- A new request may be accepted in the cycle after resp_valid, when the unit is back in IDLE.
- Reset mid-operation: the next edge returns to IDLE with no response. mem_we is low in any cycle where reset=1, so no partial RMW write is committed.

Optional Feature:
- Macro: MEM_ACCESS_MISALIGN_TRAP_EN.
- Defined: misaligned accesses go to ERR with resp_err=1 and no RAM access.
- Undefined: misalignment is not checked. The address is truncated to natural alignment (addr[0] cleared for halfwords, addr[1:0] cleared for words) and the access proceeds normally. resp_err then reports only illegal funct3.

Test Plan:
- RAM word 0x10 = 0x8899AABB; LB at addr 0x11 → resp_rdata=0xFFFFFFAA, resp_err=0, resp_valid 2 cycles after accept. LBU at 0x11 → 0x000000AA.
- LH at 0x12 → 0xFFFF8899. LW at 0x10 → 0x8899AABB. req_ready=0 for 2 cycles after each accept.
- SB 0x5C at 0x13, then LW at 0x10 → 0x5C99AABB. mem_we high exactly one cycle; resp_valid 3 cycles after accept.
- SW 0xDEADBEEF at 0x20 → no RAM read state; mem_wd=0xDEADBEEF with mem_we=1 in cycle 1; resp_valid in cycle 2.
- LW at 0x22 with the trap macro defined → resp_err=1, resp_rdata=0, mem_we never asserted, resp_valid 1 cycle after accept. Without the macro → the word at 0x20 is returned. Store with funct3=011 → resp_err=1 in both builds.
- Assert reset during the WRITE cycle of an SB → mem_we=0 that cycle, RAM word unchanged, no resp_valid, req_ready=1 after the reset edge.

Source files
------------

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// Load/store initiator for the multicycle core. Takes one RISC-V load or store
// (LB/LH/LW/LBU/LHU/SB/SH/SW, chosen by funct3) per request and drives the
// word-addressed data RAM. The RAM has no byte enables, so SB/SH are done as
// read-modify-write: read the word, merge the new byte/half, write it back.
// Load data is extracted from the addressed lane and sign/zero-extended.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   req_valid/req_ready request handshake (ready only while IDLE)
//   req_we              1 = store, 0 = load
//   req_funct3          RISC-V size/sign code
//   req_addr            byte address
//   req_wdata           store data, right-aligned
//   resp_valid          one-cycle completion pulse
//   resp_rdata          extended load data (0 for stores and errors)
//   resp_err            illegal funct3 (or misaligned, see macro below)
//   mem_we/mem_a/mem_wd RAM write enable, word-aligned byte address, write data
//   mem_rd              RAM combinational read data
//
// Build option:
//   MEM_ACCESS_MISALIGN_TRAP_EN  defined   : misaligned accesses end in ERR
//                                           with no RAM access.
//                                undefined : the address is truncated to
//                                           natural alignment and the access
//                                           proceeds; only illegal funct3
//                                           raises resp_err.
// -----------------------------------------------------------------------------
module mem_access_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic [DATA_WIDTH-1:0] mem_wd,
    input  logic [DATA_WIDTH-1:0] mem_rd
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

    // Pick the addressed lane of a RAM word and extend it according to funct3.
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [2:0]  f3,
                                                 input logic [1:0]  lane);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (lane)
            2'b00:   b = word[7:0];
            2'b01:   b = word[15:8];
            2'b10:   b = word[23:16];
            2'b11:   b = word[31:24];
            default: b = 8'h00;
        endcase
        if (lane[1]) begin
            h = word[31:16];
        end else begin
            h = word[15:0];
        end
        case (f3)
            3'b000:  res = {{24{b[7]}}, b};
            3'b001:  res = {{16{h[15]}}, h};
            3'b010:  res = word;
            3'b100:  res = {24'h000000, b};
            3'b101:  res = {16'h0000, h};
            default: res = 32'h0000_0000;
        endcase
        return res;
    endfunction

    // Replace the addressed byte (SB) or half (SH) of a RAM word; keep the rest.
    function automatic logic [31:0] store_merge(input logic [31:0] word,
                                                input logic [15:0] wd,
                                                input logic [2:0]  f3,
                                                input logic [1:0]  lane);
        logic [31:0] res;
        res = word;
        case (f3)
            3'b000: begin
                case (lane)
                    2'b00:   res[7:0]   = wd[7:0];
                    2'b01:   res[15:8]  = wd[7:0];
                    2'b10:   res[23:16] = wd[7:0];
                    2'b11:   res[31:24] = wd[7:0];
                    default: res        = word;
                endcase
            end
            3'b001: begin
                if (lane[1]) begin
                    res[31:16] = wd;
                end else begin
                    res[15:0] = wd;
                end
            end
            default: res = word;
        endcase
        return res;
    endfunction

    state_t                  state_r;
    state_t                  next_state_s;

    logic                    accept_s;
    logic                    legal_s;
    logic                    go_err_s;
    logic                    is_sw_s;
    logic [ADDR_WIDTH-1:0]   addr_nat_s;

    logic                    we_r;
    logic [2:0]              funct3_r;
    logic [1:0]              lane_r;
    logic [15:0]             wdata_r;

    logic                    busy_r;
    logic                    resp_valid_r;
    logic                    resp_err_r;
    logic [DATA_WIDTH-1:0]   resp_rdata_r;
    logic                    mem_we_r;
    logic [ADDR_WIDTH-1:0]   mem_a_r;
    logic [DATA_WIDTH-1:0]   mem_wd_r;

    logic                    busy_nx_s;
    logic                    resp_valid_nx_s;
    logic                    resp_err_nx_s;
    logic [DATA_WIDTH-1:0]   resp_rdata_nx_s;
    logic                    mem_we_nx_s;
    logic [ADDR_WIDTH-1:0]   mem_a_nx_s;
    logic [DATA_WIDTH-1:0]   mem_wd_nx_s;

    assign accept_s = req_valid && (state_r == ST_IDLE);
    assign is_sw_s  = req_we && (req_funct3 == 3'b010);

    // Request classification: legal funct3, alignment handling, error decision.
    always_comb begin
        legal_s    = 1'b0;
        go_err_s   = 1'b0;
        addr_nat_s = req_addr;
        if (req_we) begin
            case (req_funct3)
                3'b000, 3'b001, 3'b010: legal_s = 1'b1;
                default:                legal_s = 1'b0;
            endcase
        end else begin
            case (req_funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal_s = 1'b1;
                default:                                legal_s = 1'b0;
            endcase
        end
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        // funct3[1:0] encodes the size: 01 half, 10 word.
        case (req_funct3[1:0])
            2'b01:   go_err_s = !legal_s || req_addr[0];
            2'b10:   go_err_s = !legal_s || (req_addr[1:0] != 2'b00);
            default: go_err_s = !legal_s;
        endcase
`else
        go_err_s = !legal_s;
        // Silently truncate to natural alignment instead of trapping.
        case (req_funct3[1:0])
            2'b01:   addr_nat_s[0]   = 1'b0;
            2'b10:   addr_nat_s[1:0] = 2'b00;
            default: addr_nat_s      = req_addr;
        endcase
`endif
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (go_err_s) begin
                        next_state_s = ST_ERR;
                    end else if (is_sw_s) begin
                        next_state_s = ST_WRITE;
                    end else begin
                        next_state_s = ST_READ;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_READ: begin
                if (we_r) begin
                    next_state_s = ST_WRITE;
                end else begin
                    next_state_s = ST_DONE;
                end
            end
            ST_WRITE: next_state_s = ST_DONE;
            ST_DONE:  next_state_s = ST_IDLE;
            ST_ERR:   next_state_s = ST_IDLE;
            default:  next_state_s = ST_IDLE;
        endcase
    end

    // FSM output logic: next values of the registered outputs, so every
    // output flop already reflects the state it is being loaded alongside.
    always_comb begin
        busy_nx_s       = (next_state_s != ST_IDLE);
        resp_valid_nx_s = (next_state_s == ST_DONE) || (next_state_s == ST_ERR);
        resp_err_nx_s   = (next_state_s == ST_ERR);
        mem_we_nx_s     = (next_state_s == ST_WRITE);
        resp_rdata_nx_s = '0;
        mem_a_nx_s      = mem_a_r;
        mem_wd_nx_s     = mem_wd_r;
        if (accept_s) begin
            mem_a_nx_s = {addr_nat_s[ADDR_WIDTH-1:2], 2'b00};
        end else begin
            mem_a_nx_s = mem_a_r;
        end
        if (accept_s && is_sw_s) begin
            mem_wd_nx_s = req_wdata;
        end else if ((state_r == ST_READ) && we_r) begin
            mem_wd_nx_s = store_merge(mem_rd, wdata_r, funct3_r, lane_r);
        end else begin
            mem_wd_nx_s = mem_wd_r;
        end
        if ((state_r == ST_READ) && !we_r) begin
            resp_rdata_nx_s = load_extract(mem_rd, funct3_r, lane_r);
        end else begin
            resp_rdata_nx_s = '0;
        end
    end

    // Request fields latched on accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            we_r     <= 1'b0;
            funct3_r <= 3'b000;
            lane_r   <= 2'b00;
            wdata_r  <= 16'h0000;
        end else if (accept_s) begin
            we_r     <= req_we;
            funct3_r <= req_funct3;
            lane_r   <= addr_nat_s[1:0];
            wdata_r  <= req_wdata[15:0];
        end else begin
            we_r     <= we_r;
            funct3_r <= funct3_r;
            lane_r   <= lane_r;
            wdata_r  <= wdata_r;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r       <= 1'b0;
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= '0;
            mem_we_r     <= 1'b0;
            mem_a_r      <= '0;
            mem_wd_r     <= '0;
        end else begin
            busy_r       <= busy_nx_s;
            resp_valid_r <= resp_valid_nx_s;
            resp_err_r   <= resp_err_nx_s;
            resp_rdata_r <= resp_rdata_nx_s;
            mem_we_r     <= mem_we_nx_s;
            mem_a_r      <= mem_a_nx_s;
            mem_wd_r     <= mem_wd_nx_s;
        end
    end

    assign req_ready  = !busy_r;
    assign resp_valid = resp_valid_r;
    assign resp_err   = resp_err_r;
    assign resp_rdata = resp_rdata_r;
    // Gate with reset so a reset landing in the WRITE cycle never commits a
    // half-finished read-modify-write.
    assign mem_we     = mem_we_r && !reset;
    assign mem_a      = mem_a_r;
    assign mem_wd     = mem_wd_r;

endmodule
